mkmif_sram_model: RTL
=====================

Name: mkmif_sram_model

Overview:
- Synthesizable SPI slave that emulates the Microchip 23K640 serial SRAM: the responder end of the MKM SPI master.
- Used as the on-board/FPGA stand-in for the external memory and as the bench target for the MKM core.
- Oversamples the SPI pins in the system clock domain, decodes READ/WRITE/RDSR/WRSR, and holds a parameterized byte array.
- Provides a backdoor debug read port.

Parameters:
- MEM_ADDR_BITS, 8, byte-array depth is 2**MEM_ADDR_BITS; upper received address bits are ignored.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- spi_sclk  input  1  SPI clock from master, mode 0
- spi_cs_n  input  1  chip select, active low
- spi_di  input  1  serial data from master (MOSI)
- spi_do  output  1  serial data to master (MISO), never tristated
- status  output  8  current status register
- cmd_error  output  1  one-cycle pulse on unsupported command
- dbg_addr  input  MEM_ADDR_BITS  backdoor read address
- dbg_data  output  8  mem[dbg_addr], combinational

Behaviour:
- Reset values:
  - spi_do=0, status=8'h00 (byte mode), cmd_error=0.
  - All bit/byte counters and the FSM are cleared.
  - Array contents are undefined.
- Input synchronization:
  - spi_sclk, spi_cs_n and spi_di each pass through 2-FF synchronizers.
  - Edges are detected on the synchronized sclk.
  - The master's sclk half-period must be >=4 clk cycles; slower is always legal.
- Mode 0 timing:
  - spi_di is sampled on the detected sclk rise.
  - spi_do is updated on the detected sclk fall.
- cs_n high (synced):
  - FSM is forced to CMD, counters are cleared, spi_do=0, and any partial byte is discarded.
  - Overrides everything, including mid-byte. The next cs_n low starts a fresh command.
- FSM states: CMD, ADDR, RDATA, WDATA, RDSR, WRSR, IGNORE.
- CMD:
  - Shifts in 8 bits MSB first.
  - On the 8th rise, decodes: 0x03→ADDR (read), 0x02→ADDR (write), 0x05→RDSR, 0x01→WRSR.
  - Any other value → IGNORE, with cmd_error pulsed for one clk.
- ADDR:
  - Shifts in 16 bits MSB first; addr = low MEM_ADDR_BITS.
  - After the 16th rise, goes to RDATA or WDATA.
- RDATA:
  - On entry (and after every 8 further rises), tx_shift is loaded with mem[addr] and addr advances.
  - Each fall drives spi_do=tx_shift[7] and shifts left.
  - The first data bit appears on the fall following the 24th rise.
- WDATA:
  - Every 8th rise writes rx byte to mem[addr], then addr advances.
  - Partial bytes at cs_n high are not written.
- Address advance by mode (status[7:6]):
  - 00 byte: exactly one data byte per command. Afterwards, reads drive 0 and writes are dropped until cs_n high.
  - 10 page: addr[4:0] increments and wraps within the 32-byte page; upper bits are fixed.
  - 01 sequential: addr increments and wraps from 2**MEM_ADDR_BITS-1 to 0.
  - 11: treated as byte mode.
- RDSR: after the command byte, status is shifted out MSB first and repeats every 8 bits.
- WRSR:
  - The next 8 rises capture a byte; on the 8th, status <= {b[7:6],5'b0,b[0]}.
  - Further bits are ignored. If cs_n goes high before 8 bits, status is unchanged.
- IGNORE: spi_do=0 until cs_n high.
- Simultaneous synced rise and cs_n high in the same clk: cs_n wins.
- Reset mid-transaction aborts immediately. The array is not cleared.

Test Plan:
- Mode register round-trip:
  - Stimulus: reset; WRSR 0x41 (as MKM init); then RDSR with 16 clocks.
  - Required: status=8'h41; spi_do returns 0x41 twice; cmd_error stays 0.
- Sequential write then read:
  - Stimulus: seq mode; WRITE 0x02,0x0010,DE AD BE EF; cs_n high; READ 0x03,0x0010 with 32 data clocks.
  - Required: master receives 0xDEADBEEF; dbg_data at 0x10..0x13 = DE,AD,BE,EF.
- Sequential end-of-array wrap:
  - Stimulus: MEM_ADDR_BITS=8, seq mode; write 11 22 at 0xFF.
  - Required: mem[0xFF]=0x11, mem[0x00]=0x22.
- Page wrap:
  - Stimulus: WRSR 0x81; write 4 bytes at 0x1E.
  - Required: bytes land at 0x1E,0x1F,0x00,0x01.
- Byte mode:
  - Stimulus: byte mode; write AA BB at 0x05.
  - Required: mem[0x05]=0xAA; mem[0x06] unchanged.
- Aborts:
  - Stimulus: command 0x9F.
  - Required: one cmd_error pulse; spi_do=0 through 32 clocks.
  - Stimulus: write with cs_n high after 5 data bits.
  - Required: target byte unchanged.
  - Stimulus: reset_n low mid-read.
  - Required: spi_do=0; status=0x00.

Source files
------------

// File: rtl/mkmif_sram_model.sv
// SPI mode-0 slave emulating a 23K640 serial SRAM (READ/WRITE/RDSR/WRSR).
// SPI pins are oversampled in the clk domain; a backdoor port reads the byte array.
module mkmif_sram_model #(
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_di,
  output logic                     spi_do,
  output logic [7:0]               status,
  output logic                     cmd_error,
  input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);
  localparam int SHIFT_W = (MEM_ADDR_BITS > 8) ? MEM_ADDR_BITS : 8;
  localparam logic [MEM_ADDR_BITS-1:0] PAGE_MASK = MEM_ADDR_BITS'(31);
  localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE  = MEM_ADDR_BITS'(1);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_RDSR, ST_WRSR, ST_IGNORE
  } state_t;

  logic [1:0]               sclk_sync_reg, cs_sync_reg, di_sync_reg;
  logic                     sclk_prev_reg;
  logic                     sclk_rise, sclk_fall, cs_high, di_bit;
  state_t                   state_reg, state_next;
  logic [3:0]               cnt_reg;
  logic [SHIFT_W-2:0]       shift_reg;
  logic [SHIFT_W-1:0]       rx_word;
  logic [MEM_ADDR_BITS-1:0] addr_reg, addr_base, addr_inc;
  logic [7:0]               tx_reg, status_reg, mem_rd;
  logic                     is_read_reg, byte_done_reg, spi_do_reg, cmd_error_reg;
  logic                     byte_end, byte_mode, mem_we;
  logic [7:0]               mem [2**MEM_ADDR_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      di_sync_reg   <= 2'b00;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk};
      cs_sync_reg   <= {cs_sync_reg[0], spi_cs_n};
      di_sync_reg   <= {di_sync_reg[0], spi_di};
      sclk_prev_reg <= sclk_sync_reg[1];
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_prev_reg;
  assign cs_high   = cs_sync_reg[1];
  assign di_bit    = di_sync_reg[1];

  assign rx_word   = {shift_reg, di_bit};
  assign byte_end  = (cnt_reg[2:0] == 3'd7);
  // Mode 11 behaves like byte mode.
  assign byte_mode = (status_reg[7] == status_reg[6]);
  // On the last address rise the fresh address is still in the shifter.
  assign addr_base = (state_reg == ST_ADDR) ? rx_word[MEM_ADDR_BITS-1:0] : addr_reg;
  assign mem_rd    = mem[addr_base];
  assign dbg_data  = mem[dbg_addr];
  assign mem_we    = ~cs_high & sclk_rise & byte_end & (state_reg == ST_WDATA) &
                     ~(byte_mode & byte_done_reg);

  always_comb begin
    addr_inc = addr_base + ADDR_ONE;
    if (status_reg[7:6] == 2'b10)
      addr_inc = (addr_base & ~PAGE_MASK) | ((addr_base + ADDR_ONE) & PAGE_MASK);
  end

  always_comb begin
    state_next = state_reg;
    if (cs_high) begin
      state_next = ST_CMD;
    end else if (sclk_rise) begin
      case (state_reg)
        ST_CMD: begin
          if (byte_end) begin
            case (rx_word[7:0])
              8'h02, 8'h03: state_next = ST_ADDR;
              8'h05:        state_next = ST_RDSR;
              8'h01:        state_next = ST_WRSR;
              default:      state_next = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (cnt_reg == 4'd15) state_next = is_read_reg ? ST_RDATA : ST_WDATA;
        // Bits after the status byte are don't-care, which IGNORE already provides.
        ST_WRSR: if (byte_end) state_next = ST_IGNORE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_CMD;
      cnt_reg       <= 4'd0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      tx_reg        <= 8'h00;
      status_reg    <= 8'h00;
      is_read_reg   <= 1'b0;
      byte_done_reg <= 1'b0;
      spi_do_reg    <= 1'b0;
      cmd_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_error_reg <= 1'b0;
      if (cs_high) begin
        cnt_reg       <= 4'd0;
        shift_reg     <= '0;
        tx_reg        <= 8'h00;
        byte_done_reg <= 1'b0;
        spi_do_reg    <= 1'b0;
      end else if (sclk_rise) begin
        shift_reg <= rx_word[SHIFT_W-2:0];
        cnt_reg   <= cnt_reg + 4'd1;
        case (state_reg)
          ST_CMD: begin
            if (byte_end) begin
              cnt_reg     <= 4'd0;
              is_read_reg <= (rx_word[7:0] == 8'h03);
              if (rx_word[7:0] == 8'h05) tx_reg <= status_reg;
              if (state_next == ST_IGNORE) cmd_error_reg <= 1'b1;
            end
          end
          ST_ADDR: begin
            if (cnt_reg == 4'd15) begin
              cnt_reg <= 4'd0;
              if (is_read_reg) begin
                tx_reg        <= mem_rd;
                addr_reg      <= addr_inc;
                byte_done_reg <= 1'b1;
              end else begin
                addr_reg <= addr_base;
              end
            end
          end
          ST_RDATA: begin
            if (byte_end) begin
              cnt_reg       <= 4'd0;
              tx_reg        <= (byte_mode && byte_done_reg) ? 8'h00 : mem_rd;
              addr_reg      <= addr_inc;
              byte_done_reg <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (byte_end) begin
              cnt_reg <= 4'd0;
              if (mem_we) begin
                addr_reg      <= addr_inc;
                byte_done_reg <= 1'b1;
              end
            end
          end
          ST_RDSR: begin
            if (byte_end) begin
              cnt_reg <= 4'd0;
              tx_reg  <= status_reg;
            end
          end
          ST_WRSR: begin
            if (byte_end) status_reg <= {rx_word[7:6], 5'b00000, rx_word[0]};
          end
          default: ;
        endcase
      end else if (sclk_fall) begin
        if (state_reg == ST_RDATA || state_reg == ST_RDSR) begin
          spi_do_reg <= tx_reg[7];
          tx_reg     <= {tx_reg[6:0], 1'b0};
        end else begin
          spi_do_reg <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_reg] <= rx_word[7:0];
  end

  assign spi_do    = spi_do_reg;
  assign status    = status_reg;
  assign cmd_error = cmd_error_reg;
endmodule
